// File: rtl/mux_pkg.sv
// Shared constants and helpers for the 4:1 arbitrated multiplexer.
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // Index of the set bit in a one-hot vector. An all-zero input gives 0.
    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_CH-1:0] onehot);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (onehot[i]) begin
                idx = idx | SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Four-requester arbiter producing a one-hot grant.
// MUX_ROUND_ROBIN_EN defined  : rotating priority that starts at ptr and wraps;
//                               ptr moves to one past the winner when a grant is used.
// MUX_ROUND_ROBIN_EN undefined: fixed priority, requester 0 highest; no state.
module rr_arbiter_4
    import mux_pkg::*;
(
`ifdef MUX_ROUND_ROBIN_EN
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
`endif
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] grant
);

`ifdef MUX_ROUND_ROBIN_EN
    logic [SEL_W-1:0]  ptr_reg;
    logic [SEL_W-1:0]  ptr_next;
    logic [NUM_CH-1:0] rot_req;
    logic [NUM_CH-1:0] rot_grant;

    // Rotate requests so that the current pointer lands on bit 0, pick the
    // lowest set bit, then rotate the winner back into channel order.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
            assign rot_req[gi] = req[ptr_reg + SEL_W'(gi)];
            assign grant[gi]   = rot_grant[SEL_W'(gi) - ptr_reg];
        end
    endgenerate

    assign rot_grant = rot_req & (~rot_req + NUM_CH'(1));

    // Pointer advances to one past the winner only when its word is taken.
    always_comb begin
        ptr_next = ptr_reg;
        if (advance) begin
            ptr_next = onehot_to_idx(grant) + SEL_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
`else
    // Lowest-numbered requester wins.
    assign grant = req & (~req + NUM_CH'(1));
`endif

endmodule

// File: rtl/mux_4x1_rr.sv
// 4:1 multiplexer with valid/ready handshakes on every channel and a single
// registered output slot. The slot reloads whenever it is empty or being
// drained, so one word per cycle flows when out_ready stays high.
// Arbitration mode is selected by MUX_ROUND_ROBIN_EN (see rr_arbiter_4).
module mux_4x1_rr
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0]  ch_word [NUM_CH];
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              load;
    logic              accept;

    logic [WIDTH-1:0]  out_data_reg,  out_data_next;
    logic [SEL_W-1:0]  out_sel_reg,   out_sel_next;
    logic              out_valid_reg, out_valid_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_word[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter_4 u_arb (
`ifdef MUX_ROUND_ROBIN_EN
        .clk     (clk),
        .rst     (rst),
        .advance (accept),
`endif
        .req     (in_valid),
        .grant   (grant)
    );

    // Output slot is free when empty or when its word leaves this cycle;
    // nothing is accepted while reset is held.
    always_comb begin
        load      = !out_valid_reg || out_ready;
        in_ready  = (rst || !load) ? '0 : grant;
        accept    = |in_ready;
        grant_idx = onehot_to_idx(grant);
    end

    // Next output slot contents: capture the granted word, or empty the
    // slot when it drains with nothing to replace it; otherwise hold.
    always_comb begin
        out_data_next  = out_data_reg;
        out_sel_next   = out_sel_reg;
        out_valid_next = out_valid_reg;
        if (load) begin
            if (accept) begin
                out_data_next  = ch_word[grant_idx];
                out_sel_next   = grant_idx;
                out_valid_next = 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
        end
    end

    // Output slot register; reset discards any pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_data_reg  <= out_data_next;
            out_sel_reg   <= out_sel_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;
    assign out_valid = out_valid_reg;

endmodule
